// File: rtl/fadd_rr_arbiter.sv
// Round-robin front end that shares one fixed-latency, non-stalling FP adder among N_REQ requesters.
// Define FADD_RR_ARBITER_STATS_EN to add per-requester accept counters (grant_cnt_o, stats_clr_i).
module fadd_rr_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = $clog2(N_REQ),
    parameter int unsigned ADD_LAT = 4,
    parameter int unsigned MAX_OUT = 3
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [N_REQ-1:0]    req_valid_i,
    output logic [N_REQ-1:0]    req_ready_o,
    input  logic [32*N_REQ-1:0] req_a_i,
    input  logic [32*N_REQ-1:0] req_b_i,
    input  logic                hold_i,
    output logic                add_valid_o,
    output logic [31:0]         add_a_o,
    output logic [31:0]         add_b_o,
    input  logic [31:0]         add_result_i,
    input  logic                add_ready_i,
    output logic                res_valid_o,
    output logic [31:0]         res_data_o,
    output logic [ID_W-1:0]     res_id_o,
    output logic                idle_o,
    output logic                err_o
`ifdef FADD_RR_ARBITER_STATS_EN
    ,
    input  logic                stats_clr_i,
    output logic [16*N_REQ-1:0] grant_cnt_o
`endif
);

    localparam int unsigned NStages = ADD_LAT + 1;

    // Unpacked views of the packed operand buses.
    logic [31:0] req_a_arr [N_REQ];
    logic [31:0] req_b_arr [N_REQ];

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_unpack
        assign req_a_arr[g] = req_a_i[32*g +: 32];
        assign req_b_arr[g] = req_b_i[32*g +: 32];
    end

    logic [N_REQ-1:0] eligible;
    logic             grant_vld;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  cand_id;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               add_valid_q;
    logic [31:0]        add_a_q, add_a_d;
    logic [31:0]        add_b_q, add_b_d;
    logic [NStages-1:0] tag_vld_q;
    logic [ID_W-1:0]    tag_id_q [NStages];
    logic               head_vld;
    logic [ID_W-1:0]    head_id;
    logic               res_valid_q;
    logic [31:0]        res_data_q;
    logic [ID_W-1:0]    res_id_q;
    logic               err_q;
    logic [2:0]         out_cnt_q [N_REQ];
    logic [2:0]         out_cnt_d [N_REQ];
    logic [N_REQ-1:0]   cnt_inc;
    logic [N_REQ-1:0]   cnt_dec;
    logic               cnt_zero;

    // Eligibility deliberately ignores results retiring this cycle.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid_i[i] & ~hold_i & (out_cnt_q[i] < 3'(MAX_OUT));
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand_id   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand_id = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
            if (!grant_vld && eligible[cand_id]) begin
                grant_vld = 1'b1;
                grant_id  = cand_id;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (grant_vld) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        if (grant_vld) begin
            rr_ptr_d = grant_id;
            add_a_d  = req_a_arr[grant_id];
            add_b_d  = req_b_arr[grant_id];
        end
    end

    assign head_vld = tag_vld_q[NStages-1];
    assign head_id  = tag_id_q[NStages-1];

    always_comb begin
        cnt_inc = '0;
        cnt_dec = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cnt_inc[i]   = grant_vld & (grant_id == ID_W'(i));
            cnt_dec[i]   = res_valid_q & (res_id_q == ID_W'(i));
            out_cnt_d[i] = out_cnt_q[i];
            if (cnt_inc[i] && !cnt_dec[i]) begin
                out_cnt_d[i] = out_cnt_q[i] + 3'd1;
            end else if (cnt_dec[i] && !cnt_inc[i]) begin
                out_cnt_d[i] = out_cnt_q[i] - 3'd1;
            end
        end
    end

    always_comb begin
        cnt_zero = 1'b1;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (out_cnt_q[i] != 3'd0) begin
                cnt_zero = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rr_ptr_q    <= '0;
            add_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            tag_vld_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            err_q       <= 1'b0;
            for (int unsigned s = 0; s < NStages; s++) begin
                tag_id_q[s] <= '0;
            end
            for (int unsigned i = 0; i < N_REQ; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            add_valid_q <= grant_vld;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            // Tag enters on the accept edge; the last stage lines up with add_ready_i.
            tag_vld_q   <= {tag_vld_q[NStages-2:0], grant_vld};
            tag_id_q[0] <= grant_id;
            for (int unsigned s = 1; s < NStages; s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
            res_valid_q <= head_vld;
            res_id_q    <= head_id;
            res_data_q  <= add_result_i;
            if (add_ready_i != head_vld) begin
                err_q <= 1'b1;
            end
            for (int unsigned i = 0; i < N_REQ; i++) begin
                out_cnt_q[i] <= out_cnt_d[i];
            end
        end
    end

    assign add_valid_o = add_valid_q;
    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_id_o    = res_id_q;
    assign err_o       = err_q;
    assign idle_o      = cnt_zero & ~add_valid_q;

`ifdef FADD_RR_ARBITER_STATS_EN
    logic [15:0] grant_cnt_q [N_REQ];

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge Clk) begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (Rst || stats_clr_i) begin
                grant_cnt_q[i] <= '0;
            end else if (cnt_inc[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_stats
        assign grant_cnt_o[16*g +: 16] = grant_cnt_q[g];
    end
`endif

endmodule
